// File: rtl/scalar_alu_arbiter_if.sv
// Per-requester request/response bundle for the shared scalar ALU arbiter.
// The requester side uses the master modport, the arbiter uses slave.
interface scalar_alu_arbiter_if #(
  parameter int unsigned DATA_LEN       = 32,
  parameter int unsigned SCALAR_REG_LEN = 64,
  parameter int unsigned TAG_LEN        = 4
);
  logic                      req_valid;
  logic                      req_ready;
  logic [SCALAR_REG_LEN-1:0] req_rs1;
  logic [SCALAR_REG_LEN-1:0] req_rs2;
  logic [SCALAR_REG_LEN-1:0] req_imm;
  logic [DATA_LEN-1:0]       req_pc;
  logic [2:0]                req_alu_signal;
  logic [3:0]                req_func_code;
  logic [TAG_LEN-1:0]        req_tag;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [SCALAR_REG_LEN-1:0] rsp_result;
  logic [1:0]                rsp_sign_bits;
  logic [TAG_LEN-1:0]        rsp_tag;

  modport master (
    output req_valid, req_rs1, req_rs2, req_imm, req_pc, req_alu_signal, req_func_code, req_tag,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_sign_bits, rsp_tag
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_imm, req_pc, req_alu_signal, req_func_code, req_tag,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_sign_bits, rsp_tag
  );
endinterface

// File: rtl/scalar_alu_arbiter.sv
// Round-robin arbiter sharing one combinational scalar ALU between the scalar
// execute stage (port0) and the vector address generator (port1), with registered responses.
module scalar_alu_arbiter #(
  parameter int unsigned DATA_LEN       = 32,
  parameter int unsigned SCALAR_REG_LEN = 64,
  parameter int unsigned TAG_LEN        = 4
) (
  input logic               clk,
  input logic               rst,
  scalar_alu_arbiter_if.slave port0,
  scalar_alu_arbiter_if.slave port1
);

  localparam int unsigned ShW = $clog2(SCALAR_REG_LEN);

  localparam logic [2:0] SigNop        = 3'd0;
  localparam logic [2:0] SigBinary     = 3'd1;
  localparam logic [2:0] SigImmBinary  = 3'd2;
  localparam logic [2:0] SigBranchCond = 3'd3;
  localparam logic [2:0] SigMemAddr    = 3'd4;
  localparam logic [2:0] SigPcBased    = 3'd5;
  localparam logic [2:0] SigImm        = 3'd6;

  localparam logic [3:0] FnAdd  = 4'd0;
  localparam logic [3:0] FnSub  = 4'd1;
  localparam logic [3:0] FnAnd  = 4'd2;
  localparam logic [3:0] FnOr   = 4'd3;
  localparam logic [3:0] FnXor  = 4'd4;
  localparam logic [3:0] FnSll  = 4'd5;
  localparam logic [3:0] FnSrl  = 4'd6;
  localparam logic [3:0] FnSra  = 4'd7;
  localparam logic [3:0] FnSlt  = 4'd8;
  localparam logic [3:0] FnSltu = 4'd9;

  localparam logic [1:0] SignZero = 2'd0;
  localparam logic [1:0] SignPos  = 2'd1;
  localparam logic [1:0] SignNeg  = 2'd2;

  typedef logic [SCALAR_REG_LEN-1:0] word_t;

  function automatic word_t binop(input logic [3:0] fc, input word_t a, input word_t b);
    logic [ShW-1:0] sh;
    sh = b[ShW-1:0];
    case (fc)
      FnAdd:   return a + b;
      FnSub:   return a - b;
      FnAnd:   return a & b;
      FnOr:    return a | b;
      FnXor:   return a ^ b;
      FnSll:   return a << sh;
      FnSrl:   return a >> sh;
      FnSra:   return $unsigned($signed(a) >>> sh);
      FnSlt:   return {{(SCALAR_REG_LEN-1){1'b0}}, $signed(a) < $signed(b)};
      FnSltu:  return {{(SCALAR_REG_LEN-1){1'b0}}, a < b};
      default: return '0;
    endcase
  endfunction

  // Port-indexed views of the two request bundles.
  logic [1:0]                     req_valid, rsp_ready;
  logic [1:0][SCALAR_REG_LEN-1:0] req_rs1, req_rs2, req_imm;
  logic [1:0][DATA_LEN-1:0]       req_pc;
  logic [1:0][2:0]                req_alu_signal;
  logic [1:0][3:0]                req_func_code;
  logic [1:0][TAG_LEN-1:0]        req_tag;

  assign req_valid      = {port1.req_valid, port0.req_valid};
  assign rsp_ready      = {port1.rsp_ready, port0.rsp_ready};
  assign req_rs1        = {port1.req_rs1, port0.req_rs1};
  assign req_rs2        = {port1.req_rs2, port0.req_rs2};
  assign req_imm        = {port1.req_imm, port0.req_imm};
  assign req_pc         = {port1.req_pc, port0.req_pc};
  assign req_alu_signal = {port1.req_alu_signal, port0.req_alu_signal};
  assign req_func_code  = {port1.req_func_code, port0.req_func_code};
  assign req_tag        = {port1.req_tag, port0.req_tag};

  logic                           last_grant_q, last_grant_d;
  logic [1:0]                     rsp_valid_q, rsp_valid_d;
  logic [1:0][SCALAR_REG_LEN-1:0] rsp_result_q, rsp_result_d;
  logic [1:0][1:0]                rsp_sign_q, rsp_sign_d;
  logic [1:0][TAG_LEN-1:0]        rsp_tag_q, rsp_tag_d;

  logic [1:0] eligible, grant;
  logic       sel;

  // A slot being drained this cycle can accept a new result in the same cycle.
  assign eligible = req_valid & (~rsp_valid_q | rsp_ready);
  assign sel      = grant[1];

  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      unique case (eligible)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  logic [2:0]                alu_signal;
  logic [3:0]                alu_func;
  logic [SCALAR_REG_LEN-1:0] alu_rs1, alu_rs2, alu_imm, alu_pc, alu_result;
  logic [1:0]                alu_sign;
  logic [SCALAR_REG_LEN-1:0] cap_result;
  logic [1:0]                cap_sign;

  always_comb begin
    alu_signal = SigNop;
    alu_func   = '0;
    alu_rs1    = '0;
    alu_rs2    = '0;
    alu_imm    = '0;
    alu_pc     = '0;
    if (|grant) begin
      alu_signal = req_alu_signal[sel];
      alu_func   = req_func_code[sel];
      alu_rs1    = req_rs1[sel];
      alu_rs2    = req_rs2[sel];
      alu_imm    = req_imm[sel];
      alu_pc     = {{(SCALAR_REG_LEN-DATA_LEN){1'b0}}, req_pc[sel]};
    end
  end

  // Shared scalar ALU.
  always_comb begin
    case (alu_signal)
      SigBinary:     alu_result = binop(alu_func, alu_rs1, alu_rs2);
      SigImmBinary:  alu_result = binop(alu_func, alu_rs1, alu_imm);
      SigBranchCond: alu_result = alu_rs1 - alu_rs2;
      SigMemAddr:    alu_result = alu_rs1 + alu_imm;
      SigPcBased:    alu_result = alu_pc + alu_imm;
      SigImm:        alu_result = alu_imm;
      default:       alu_result = '0;
    endcase
    if (alu_result == '0) begin
      alu_sign = SignZero;
    end else if (alu_result[SCALAR_REG_LEN-1]) begin
      alu_sign = SignNeg;
    end else begin
      alu_sign = SignPos;
    end
  end

  // NOP results are forced here rather than trusted from the ALU.
  assign cap_result = (alu_signal == SigNop) ? '0 : alu_result;
  assign cap_sign   = (alu_signal == SigNop) ? SignZero : alu_sign;

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_sign_d   = rsp_sign_q;
    rsp_tag_d    = rsp_tag_q;
    last_grant_d = last_grant_q;
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
      if (grant[i]) begin
        rsp_valid_d[i]  = 1'b1;
        rsp_result_d[i] = cap_result;
        rsp_sign_d[i]   = cap_sign;
        rsp_tag_d[i]    = req_tag[i];
        last_grant_d    = (i == 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_sign_q   <= '0;
      rsp_tag_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_sign_q   <= rsp_sign_d;
      rsp_tag_q    <= rsp_tag_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign port0.req_ready     = grant[0];
  assign port0.rsp_valid     = rsp_valid_q[0];
  assign port0.rsp_result    = rsp_result_q[0];
  assign port0.rsp_sign_bits = rsp_sign_q[0];
  assign port0.rsp_tag       = rsp_tag_q[0];

  assign port1.req_ready     = grant[1];
  assign port1.rsp_valid     = rsp_valid_q[1];
  assign port1.rsp_result    = rsp_result_q[1];
  assign port1.rsp_sign_bits = rsp_sign_q[1];
  assign port1.rsp_tag       = rsp_tag_q[1];

endmodule

// File: tb/tb_scalar_alu_arbiter.sv
// Bench for scalar_alu_arbiter: directed scenarios plus a randomized run against
// a behavioural model of the round-robin ALU sharing.
module tb_scalar_alu_arbiter;

  localparam logic [2:0] SigNop = 3'd0, SigBinary = 3'd1, SigImmBinary = 3'd2,
                         SigBranchCond = 3'd3, SigMemAddr = 3'd4, SigPcBased = 3'd5, SigImm = 3'd6;
  localparam logic [3:0] FnAdd = 4'd0, FnSub = 4'd1, FnSra = 4'd7;
  localparam logic [1:0] SignZero = 2'd0, SignPos = 2'd1, SignNeg = 2'd2;

  typedef struct {
    logic        valid;
    logic [2:0]  sig;
    logic [3:0]  fc;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [31:0] pc;
    logic [3:0]  tag;
  } req_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  scalar_alu_arbiter_if #(.DATA_LEN(32), .SCALAR_REG_LEN(64), .TAG_LEN(4)) p0 ();
  scalar_alu_arbiter_if #(.DATA_LEN(32), .SCALAR_REG_LEN(64), .TAG_LEN(4)) p1 ();

  scalar_alu_arbiter #(.DATA_LEN(32), .SCALAR_REG_LEN(64), .TAG_LEN(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .port0 (p0),
    .port1 (p1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus state and behavioural model state.
  req_t        req [2];
  logic        rsp_rdy [2];
  logic [1:0]  m_valid;
  logic [63:0] m_result [2];
  logic [1:0]  m_sign [2];
  logic [3:0]  m_tag [2];
  int          m_last;
  logic [1:0]  obs_rdy, exp_rdy, obs_valid;
  logic [63:0] obs_result [2];
  logic [1:0]  obs_sign [2];
  logic [3:0]  obs_tag [2];

  function automatic logic [63:0] ref_result(input req_t r);
    logic [63:0] b;
    b = (r.sig == SigImmBinary) ? r.imm : r.rs2;
    case (r.sig)
      SigBinary, SigImmBinary: begin
        case (r.fc)
          4'd0: return r.rs1 + b;
          4'd1: return r.rs1 - b;
          4'd2: return r.rs1 & b;
          4'd3: return r.rs1 | b;
          4'd4: return r.rs1 ^ b;
          4'd5: return r.rs1 << b[5:0];
          4'd6: return r.rs1 >> b[5:0];
          4'd7: return $unsigned($signed(r.rs1) >>> b[5:0]);
          4'd8: return ($signed(r.rs1) < $signed(b)) ? 64'd1 : 64'd0;
          4'd9: return (r.rs1 < b) ? 64'd1 : 64'd0;
          default: return 64'd0;
        endcase
      end
      SigBranchCond: return r.rs1 - r.rs2;
      SigMemAddr:    return r.rs1 + r.imm;
      SigPcBased:    return {32'd0, r.pc} + r.imm;
      SigImm:        return r.imm;
      default:       return 64'd0;
    endcase
  endfunction

  function automatic logic [1:0] ref_sign(input logic [63:0] v);
    if (v == 64'd0) return SignZero;
    if ($signed(v) < 0) return SignNeg;
    return SignPos;
  endfunction

  task automatic model_reset();
    m_valid = 2'b00;
    m_last  = 1;
    for (int i = 0; i < 2; i++) begin
      m_result[i] = '0;
      m_sign[i]   = '0;
      m_tag[i]    = '0;
    end
  endtask

  // Round-robin: an eligible port wins unless both are eligible, then the port that lost last.
  function automatic logic [1:0] predict();
    logic [1:0] el, g;
    g = 2'b00;
    if (rst) return g;
    for (int i = 0; i < 2; i++) el[i] = req[i].valid && (!m_valid[i] || rsp_rdy[i]);
    if (el == 2'b11) g[1 - m_last] = 1'b1;
    else g = el;
    return g;
  endfunction

  task automatic model_step(input logic [1:0] g);
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i] && rsp_rdy[i]) m_valid[i] = 1'b0;
      if (g[i]) begin
        m_valid[i]  = 1'b1;
        m_result[i] = ref_result(req[i]);
        m_sign[i]   = ref_sign(m_result[i]);
        m_tag[i]    = req[i].tag;
        m_last      = i;
      end
    end
  endtask

  task automatic drive();
    p0.req_valid = req[0].valid; p0.req_alu_signal = req[0].sig; p0.req_func_code = req[0].fc;
    p0.req_rs1 = req[0].rs1; p0.req_rs2 = req[0].rs2; p0.req_imm = req[0].imm;
    p0.req_pc = req[0].pc; p0.req_tag = req[0].tag; p0.rsp_ready = rsp_rdy[0];
    p1.req_valid = req[1].valid; p1.req_alu_signal = req[1].sig; p1.req_func_code = req[1].fc;
    p1.req_rs1 = req[1].rs1; p1.req_rs2 = req[1].rs2; p1.req_imm = req[1].imm;
    p1.req_pc = req[1].pc; p1.req_tag = req[1].tag; p1.rsp_ready = rsp_rdy[1];
  endtask

  task automatic set_req(input int i, input logic [2:0] sig, input logic [3:0] fc,
                         input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                         input logic [31:0] pc, input logic [3:0] tag);
    req[i].valid = 1'b1; req[i].sig = sig; req[i].fc = fc; req[i].rs1 = rs1;
    req[i].rs2 = rs2; req[i].imm = imm; req[i].pc = pc; req[i].tag = tag;
  endtask

  function automatic logic [63:0] rand_word();
    if ($urandom_range(0, 1) == 1) return {$urandom, $urandom};
    return 64'($urandom_range(0, 100));
  endfunction

  task automatic rand_req(input int i);
    set_req(i, 3'($urandom_range(0, 6)), 4'($urandom_range(0, 9)), rand_word(), rand_word(),
            rand_word(), $urandom, 4'($urandom));
  endtask

  task automatic sample_rsp();
    obs_valid     = {p1.rsp_valid, p0.rsp_valid};
    obs_result[0] = p0.rsp_result; obs_sign[0] = p0.rsp_sign_bits; obs_tag[0] = p0.rsp_tag;
    obs_result[1] = p1.rsp_result; obs_sign[1] = p1.rsp_sign_bits; obs_tag[1] = p1.rsp_tag;
  endtask

  // Entered at posedge+1 with inputs driven; samples ready, advances the model and the clock.
  task automatic tick();
    logic [1:0] g;
    #1;
    obs_rdy = {p1.req_ready, p0.req_ready};
    g       = predict();
    exp_rdy = g;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(g);
    #1;
    sample_rsp();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req[0].valid = 1'b0; req[1].valid = 1'b0;
    drive();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rand_req(0); rand_req(1);
    rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
    drive();
    tick();
    checks++;
    if (obs_rdy !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b exp 00", obs_rdy);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_valid[i] !== 1'b0 || obs_result[i] !== 64'd0 || obs_sign[i] !== 2'd0 ||
          obs_tag[i] !== 4'd0) begin
        errors++;
        $display("FAIL reset_state port%0d got v=%b r=%h s=%b t=%h exp all zero", i,
                 obs_valid[i], obs_result[i], obs_sign[i], obs_tag[i]);
      end
    end
    rst = 1'b0;
    req[0].valid = 1'b0; req[1].valid = 1'b0;
    drive();
  endtask

  task automatic test_single();
    set_req(0, SigBinary, FnAdd, 64'd5, 64'd7, 64'd0, 32'd0, 4'd3);
    req[1].valid = 1'b0;
    rsp_rdy[0] = 1'b1;
    drive();
    tick();
    checks++;
    if (obs_rdy !== 2'b01) begin
      errors++; $display("FAIL single_ready got %b exp 01", obs_rdy);
    end
    checks++;
    if (obs_valid[0] !== 1'b1 || obs_result[0] !== 64'd12 || obs_sign[0] !== SignPos ||
        obs_tag[0] !== 4'd3) begin
      errors++;
      $display("FAIL single_rsp got v=%b r=%0d s=%b t=%0d exp v=1 r=12 s=01 t=3",
               obs_valid[0], obs_result[0], obs_sign[0], obs_tag[0]);
    end
    req[0].valid = 1'b0;
    drive();
    tick();
    checks++;
    if (obs_valid[0] !== 1'b0 || obs_result[0] !== 64'd12) begin
      errors++;
      $display("FAIL single_drain got v=%b r=%0d exp v=0 r=12", obs_valid[0], obs_result[0]);
    end
  endtask

  task automatic test_alternate();
    req_t       saved [2];
    int         p;
    logic [1:0] want;
    do_reset();
    rand_req(0); rand_req(1);
    rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
    drive();
    for (int k = 0; k < 8; k++) begin
      saved = req;
      tick();
      p    = k % 2;
      want = (p == 0) ? 2'b01 : 2'b10;
      checks++;
      if (obs_rdy !== want) begin
        errors++; $display("FAIL alt_grant cyc %0d got %b exp %b", k, obs_rdy, want);
      end
      checks++;
      if (obs_valid !== want || obs_result[p] !== ref_result(saved[p]) ||
          obs_tag[p] !== saved[p].tag) begin
        errors++;
        $display("FAIL alt_rsp cyc %0d got v=%b r=%h t=%h exp v=%b r=%h t=%h", k, obs_valid,
                 obs_result[p], obs_tag[p], want, ref_result(saved[p]), saved[p].tag);
      end
      rand_req(p);
      drive();
    end
  endtask

  task automatic test_backpressure();
    req_t save1, s0, s1;
    do_reset();
    req[0].valid = 1'b0;
    set_req(1, SigImm, FnAdd, 64'd0, 64'd0, {$urandom, 32'h0000_1234}, 32'd0, 4'd9);
    rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b0;
    save1 = req[1];
    drive();
    tick();
    checks++;
    if (obs_rdy !== 2'b10 || obs_valid[1] !== 1'b1 || obs_result[1] !== save1.imm) begin
      errors++;
      $display("FAIL bp_first got rdy=%b v=%b r=%h exp rdy=10 v=1 r=%h", obs_rdy, obs_valid[1],
               obs_result[1], save1.imm);
    end
    rand_req(0); rand_req(1);
    drive();
    for (int k = 0; k < 4; k++) begin
      s0 = req[0];
      tick();
      checks++;
      if (obs_rdy !== 2'b01) begin
        errors++; $display("FAIL bp_grant cyc %0d got %b exp 01", k, obs_rdy);
      end
      checks++;
      if (obs_valid[1] !== 1'b1 || obs_result[1] !== save1.imm || obs_tag[1] !== 4'd9) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v=%b r=%h t=%h exp v=1 r=%h t=9", k, obs_valid[1],
                 obs_result[1], obs_tag[1], save1.imm);
      end
      checks++;
      if (obs_result[0] !== ref_result(s0) || obs_tag[0] !== s0.tag) begin
        errors++;
        $display("FAIL bp_port0 cyc %0d got r=%h t=%h exp r=%h t=%h", k, obs_result[0],
                 obs_tag[0], ref_result(s0), s0.tag);
      end
      rand_req(0);
      drive();
    end
    rsp_rdy[1] = 1'b1;
    s1 = req[1];
    drive();
    tick();
    checks++;
    if (obs_rdy !== 2'b10 || obs_result[1] !== ref_result(s1) || obs_tag[1] !== s1.tag) begin
      errors++;
      $display("FAIL bp_release got rdy=%b r=%h t=%h exp rdy=10 r=%h t=%h", obs_rdy,
               obs_result[1], obs_tag[1], ref_result(s1), s1.tag);
    end
  endtask

  task automatic test_ops();
    do_reset();
    set_req(0, SigBranchCond, FnAdd, 64'd9, 64'd9, 64'd0, 32'd0, 4'd1);
    set_req(1, SigMemAddr, FnAdd, 64'h100, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 32'd0, 4'd2);
    rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
    drive();
    tick();
    checks++;
    if (obs_rdy !== 2'b01 || obs_result[0] !== 64'd0 || obs_sign[0] !== SignZero) begin
      errors++;
      $display("FAIL op_branch got rdy=%b r=%h s=%b exp rdy=01 r=0 s=00", obs_rdy,
               obs_result[0], obs_sign[0]);
    end
    req[0].valid = 1'b0;
    drive();
    tick();
    checks++;
    if (obs_rdy !== 2'b10 || obs_result[1] !== 64'hF0 || obs_sign[1] !== SignPos) begin
      errors++;
      $display("FAIL op_memaddr got rdy=%b r=%h s=%b exp rdy=10 r=f0 s=01", obs_rdy,
               obs_result[1], obs_sign[1]);
    end
    set_req(0, SigImmBinary, FnSub, 64'd3, 64'd0, 64'd5, 32'd0, 4'd4);
    set_req(1, SigPcBased, FnAdd, 64'd0, 64'd0, 64'h20, 32'h1000, 4'd5);
    drive();
    tick();
    checks++;
    if (obs_result[0] !== 64'hFFFF_FFFF_FFFF_FFFE || obs_sign[0] !== SignNeg) begin
      errors++;
      $display("FAIL op_sub got r=%h s=%b exp r=fffffffffffffffe s=10", obs_result[0],
               obs_sign[0]);
    end
    set_req(0, SigBinary, FnSra, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 32'd0, 4'd6);
    drive();
    tick();
    checks++;
    if (obs_result[1] !== 64'h1020 || obs_sign[1] !== SignPos) begin
      errors++;
      $display("FAIL op_pc got r=%h s=%b exp r=1020 s=01", obs_result[1], obs_sign[1]);
    end
    req[1].valid = 1'b0;
    drive();
    tick();
    checks++;
    if (obs_result[0] !== 64'hF800_0000_0000_0000 || obs_sign[0] !== SignNeg) begin
      errors++;
      $display("FAIL op_sra got r=%h s=%b exp r=f800000000000000 s=10", obs_result[0],
               obs_sign[0]);
    end
  endtask

  task automatic test_nop_reset();
    do_reset();
    set_req(0, SigNop, FnAdd, 64'd77, 64'd88, 64'd99, 32'h40, 4'd5);
    req[1].valid = 1'b0;
    rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
    drive();
    tick();
    checks++;
    if (obs_rdy !== 2'b01 || obs_valid[0] !== 1'b1 || obs_result[0] !== 64'd0 ||
        obs_sign[0] !== SignZero || obs_tag[0] !== 4'd5) begin
      errors++;
      $display("FAIL nop got rdy=%b v=%b r=%h s=%b t=%h exp rdy=01 v=1 r=0 s=00 t=5", obs_rdy,
               obs_valid[0], obs_result[0], obs_sign[0], obs_tag[0]);
    end
    req[0].valid = 1'b0;
    rsp_rdy[0] = 1'b0;
    rand_req(1);
    rst = 1'b1;
    drive();
    tick();
    rst = 1'b0;
    checks++;
    if (obs_rdy !== 2'b00) begin
      errors++; $display("FAIL rst_ready got %b exp 00", obs_rdy);
    end
    checks++;
    if (obs_valid !== 2'b00 || obs_result[0] !== 64'd0 || obs_tag[0] !== 4'd0 ||
        obs_result[1] !== 64'd0 || obs_tag[1] !== 4'd0) begin
      errors++;
      $display("FAIL rst_rsp got v=%b r0=%h t0=%h r1=%h t1=%h exp all zero", obs_valid,
               obs_result[0], obs_tag[0], obs_result[1], obs_tag[1]);
    end
    rand_req(0);
    rsp_rdy[0] = 1'b1;
    drive();
    tick();
    checks++;
    if (obs_rdy !== 2'b01) begin
      errors++; $display("FAIL rst_first_conflict got %b exp 01", obs_rdy);
    end
  endtask

  task automatic test_random();
    do_reset();
    req[0].valid = 1'b0; req[1].valid = 1'b0;
    drive();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req[i].valid && $urandom_range(0, 9) < 7) rand_req(i);
        rsp_rdy[i] = ($urandom_range(0, 9) < 6);
      end
      drive();
      tick();
      checks++;
      if (obs_rdy !== exp_rdy) begin
        errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, obs_rdy, exp_rdy);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_valid[i] !== m_valid[i] || obs_result[i] !== m_result[i] ||
            obs_sign[i] !== m_sign[i] || obs_tag[i] !== m_tag[i]) begin
          errors++;
          $display("FAIL rand_rsp cyc %0d port%0d got v=%b r=%h s=%b t=%h exp v=%b r=%h s=%b t=%h",
                   c, i, obs_valid[i], obs_result[i], obs_sign[i], obs_tag[i], m_valid[i],
                   m_result[i], m_sign[i], m_tag[i]);
        end
        // Accepted requests are retired; a request left waiting keeps its fields.
        if (exp_rdy[i]) req[i].valid = 1'b0;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_req(i, SigNop, FnAdd, 64'd0, 64'd0, 64'd0, 32'd0, 4'd0);
      req[i].valid = 1'b0;
      rsp_rdy[i]   = 1'b0;
    end
    model_reset();
    drive();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_ops();
    test_nop_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scalar_alu_arbiter.md
Name: scalar_alu_arbiter

Overview:
- Shares the single combinational scalar ALU instance between two requesters.
  - Port 0: the scalar pipeline execute stage.
  - Port 1: the vector load/store address generator, which uses `MEM_ADDR` / `IMM_BINARY` ops.
- Arbitration is round-robin with valid/ready handshakes.
- Each port's result is captured into a per-port response register, so each requester sees its own registered, back-pressurable result stream.
- Sits between the decode/issue logic and the scalar ALU, which is instantiated once inside this block.

Parameters:
- DATA_LEN, 32, PC width
- SCALAR_REG_LEN, 64, operand/result width
- TAG_LEN, 4, opaque requester tag, returned unchanged with the result

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req0_valid / req1_valid  input  1  request present
- req0_ready / req1_ready  output  1  request accepted this cycle (combinational grant)
- reqN_rs1, reqN_rs2, reqN_imm  input  SCALAR_REG_LEN  ALU operands
- reqN_pc  input  DATA_LEN  PC operand
- reqN_alu_signal  input  3  ALU op class (`ALU_NOP`, `BINARY`, `IMM_BINARY`, `BRANCH_COND`, `MEM_ADDR`, `PC_BASED`, `IMM`)
- reqN_func_code  input  4  function code
- reqN_tag  input  TAG_LEN  requester tag
- rsp0_valid / rsp1_valid  output  1  registered result available
- rsp0_ready / rsp1_ready  input  1  consumer takes result
- rspN_result  output  SCALAR_REG_LEN  ALU result
- rspN_sign_bits  output  2  `POS` / `ZERO` / `NEG`
- rspN_tag  output  TAG_LEN  tag of the request that produced the result

Behaviour:
- Reset (synchronous; a reset cycle overrides everything including in-flight handshakes):
  - rspN_valid=0, rspN_result=0, rspN_sign_bits=0, rspN_tag=0.
  - last_grant=1, so port 0 wins the first conflict.
- Eligibility: port i is eligible when reqi_valid && (!rspi_valid || rspi_ready), i.e. its response slot is free or is being drained this cycle.
- Grant (combinational, at most one port per cycle):
  - Exactly one port eligible: grant it.
  - Both eligible: grant the port != last_grant.
  - reqi_ready = grant[i].
  - req_ready never asserts in a reset cycle.
- Mux: the granted port's operands, alu_signal and func_code drive the ALU. With no grant, drive alu_signal=`ALU_NOP` and all operands 0.
- Handshake on port i (reqi_valid && reqi_ready):
  - Next edge: rspi_result <= ALU result, rspi_sign_bits <= ALU sign, rspi_tag <= reqi_tag, rspi_valid <= 1, last_grant <= i.
  - Latency: exactly 1 cycle from handshake to rsp_valid.
- `ALU_NOP` request: accepted normally; rsp_result=0, rsp_sign_bits=`ZERO`. The block forces these values and does not use the ALU output for NOP.
- Unsupported func_code: accepted; result is whatever the ALU produces. No error port is provided.
- Response drain:
  - rspi_valid && rspi_ready with no new handshake on port i that cycle → rspi_valid <= 0. Data registers hold their old values.
  - Drain and new handshake on the same port in the same cycle → new data is written and rsp_valid stays 1 (write wins).
- Response hold: while rspi_valid && !rspi_ready, result/sign/tag stay stable and port i is not granted. The other port may still be granted.
- Requesters must hold their request fields stable while valid && !ready. The block does not latch them before the handshake.
- No combinational path from rsp_ready to rsp_* outputs. rsp_ready → req_ready is combinational through eligibility.
- Throughput: one ALU op per cycle total. A single port can issue every cycle if its consumer holds rsp_ready=1.

Test Plan:
1. Reset, then req0 alone with `BINARY`/`ADD`, rs1=5, rs2=7, tag=3, rsp0_ready=1 → req0_ready=1 in the same cycle; next cycle rsp0_valid=1, result=12, sign=`POS`, tag=3.
2. Both ports valid every cycle, both rsp_ready=1 → grants alternate 0,1,0,1 starting with port 0; each port sees one result every 2 cycles.
3. rsp1_ready=0 after a port-1 result, req1 still valid, req0 valid → req1_ready stays 0, port 0 granted every cycle, rsp1 fields stable. Raise rsp1_ready → port 1 granted in that same cycle.
4. Port 1 `MEM_ADDR` rs1=0x100, imm=0xFFFF_FFFF_FFFF_FFF0 (−16) → result=0xF0, sign=`POS`. Port 0 `BRANCH_COND` rs1=rs2=9 → result=0, sign=`ZERO`.
5. `ALU_NOP` request on port 0 → accepted; rsp0 result=0, sign=`ZERO`. Assert rst while rsp0_valid=1 and req1 handshaking → next cycle all rsp_valid=0, outputs 0, and the next conflict goes to port 0.
